// File: rtl/minigame_dispatcher.sv
// Session controller for BitBakery: INICIAL/PREPARACAO/EXECUCAO/FIM flow over N_GAMES minigame cores,
// with abort, execution watchdog, saturating total score and session counter.
module minigame_dispatcher #(
  parameter int N_GAMES        = 3,
  parameter int SEL_W          = 2,
  parameter int BTN_W          = 7,
  parameter int LED_W          = 3,
  parameter int STATE_W        = 4,
  parameter int JOG_W          = 7,
  parameter int SCORE_W        = 7,
  parameter int TOTAL_W        = 10,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         iniciar,
  input  logic                         abortar,
  input  logic                         dificuldade,
  input  logic [SEL_W-1:0]             minigame,
  input  logic [BTN_W-1:0]             botoes,
  input  logic [N_GAMES-1:0]           game_pronto,
  input  logic [N_GAMES*LED_W-1:0]     game_leds,
  input  logic [N_GAMES*STATE_W-1:0]   game_estado,
  input  logic [N_GAMES*JOG_W-1:0]     game_jogada,
  input  logic [N_GAMES*SCORE_W-1:0]   game_pontuacao,
  output logic [N_GAMES-1:0]           game_jogar,
  output logic [N_GAMES-1:0]           game_reset,
  output logic                         game_dificuldade,
  output logic [N_GAMES*BTN_W-1:0]     game_botoes,
  output logic [SEL_W-1:0]             minigame_out,
  output logic [LED_W-1:0]             leds_out,
  output logic [STATE_W-1:0]           estado_out,
  output logic [JOG_W-1:0]             jogada_out,
  output logic [SCORE_W-1:0]           pontuacao_out,
  output logic [TOTAL_W-1:0]           pontuacao_total,
  output logic [7:0]                   partidas,
  output logic                         sel_invalida,
  output logic                         timeout
);

  typedef enum logic [1:0] {
    INICIAL    = 2'b00,
    PREPARACAO = 2'b01,
    EXECUCAO   = 2'b10,
    FIM        = 2'b11
  } state_t;

  localparam int WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int TW1     = TOTAL_W + 1;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 dif_q, dif_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [7:0]           partidas_q, partidas_d;
  logic                 sel_inv_q, sel_inv_d;
  logic                 timeout_q, timeout_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [N_GAMES-1:0]   jogar_q, jogar_d;
  logic [N_GAMES-1:0]   greset_q, greset_d;

  logic [N_GAMES-1:0]       sel_oh_s;
  logic                     show_s;
  logic                     exec_s;
  logic                     pronto_sel_s;
  logic [SCORE_W-1:0]       score_sel_s;
  logic [TW1-1:0]           sum_s;
  logic [LED_W-1:0]         leds_s;
  logic [STATE_W-1:0]       estado_mux_s;
  logic [JOG_W-1:0]         jogada_s;
  logic [SCORE_W-1:0]       pont_s;
  logic [N_GAMES*BTN_W-1:0] botoes_s;

  function automatic logic [N_GAMES-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [N_GAMES-1:0] oh;
    oh = {N_GAMES{1'b0}};
    for (int i = 0; i < N_GAMES; i++) begin
      oh[i] = (s == SEL_W'(i));
    end
    return oh;
  endfunction

  // Selected-game view: AND-OR muxes so an out-of-range selection simply reads as zero
  always_comb begin
    sel_oh_s     = sel_onehot(sel_q);
    show_s       = (state_q == EXECUCAO) || (state_q == FIM);
    exec_s       = (state_q == EXECUCAO);
    pronto_sel_s = |(game_pronto & sel_oh_s);
    score_sel_s  = {SCORE_W{1'b0}};
    leds_s       = {LED_W{1'b0}};
    estado_mux_s = {STATE_W{1'b0}};
    jogada_s     = {JOG_W{1'b0}};
    pont_s       = {SCORE_W{1'b0}};
    botoes_s     = {(N_GAMES*BTN_W){1'b0}};
    for (int i = 0; i < N_GAMES; i++) begin
      score_sel_s  = score_sel_s  | (game_pontuacao[i*SCORE_W +: SCORE_W] & {SCORE_W{sel_oh_s[i]}});
      leds_s       = leds_s       | (game_leds[i*LED_W +: LED_W] & {LED_W{sel_oh_s[i] & show_s}});
      estado_mux_s = estado_mux_s | (game_estado[i*STATE_W +: STATE_W] & {STATE_W{sel_oh_s[i]}});
      jogada_s     = jogada_s     | (game_jogada[i*JOG_W +: JOG_W] & {JOG_W{sel_oh_s[i] & show_s}});
      pont_s       = pont_s       | (game_pontuacao[i*SCORE_W +: SCORE_W] & {SCORE_W{sel_oh_s[i] & show_s}});
      botoes_s[i*BTN_W +: BTN_W] = botoes & {BTN_W{sel_oh_s[i] & exec_s}};
    end
    sum_s = {1'b0, total_q} + TW1'(score_sel_s);
  end

  // Next-state and session bookkeeping
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dif_d      = dif_q;
    total_d    = total_q;
    partidas_d = partidas_q;
    sel_inv_d  = sel_inv_q;
    timeout_d  = timeout_q;
    wd_d       = wd_q;
    jogar_d    = {N_GAMES{1'b0}};
    greset_d   = {N_GAMES{1'b0}};
    case (state_q)
      INICIAL: begin
        if (iniciar) begin
          state_d = PREPARACAO;
        end else begin
          state_d = INICIAL;
        end
      end
      PREPARACAO: begin
        if (minigame < SEL_W'(N_GAMES)) begin
          sel_d     = minigame;
          dif_d     = dificuldade;
          sel_inv_d = 1'b0;
          wd_d      = {WD_W{1'b0}};
          jogar_d   = sel_onehot(minigame);
          state_d   = EXECUCAO;
        end else begin
          sel_inv_d = 1'b1;
          state_d   = PREPARACAO;
        end
      end
      EXECUCAO: begin
        // abort beats completion, completion beats the watchdog
        if (abortar) begin
          greset_d = sel_oh_s;
          state_d  = INICIAL;
        end else if (pronto_sel_s) begin
          total_d    = sum_s[TOTAL_W] ? {TOTAL_W{1'b1}} : sum_s[TOTAL_W-1:0];
          partidas_d = (partidas_q == 8'hFF) ? 8'hFF : partidas_q + 8'd1;
          state_d    = FIM;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_W'(WD_LAST))) begin
          timeout_d = 1'b1;
          state_d   = FIM;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      FIM: begin
        if (iniciar) begin
          timeout_d = 1'b0;
          state_d   = PREPARACAO;
        end else begin
          state_d = FIM;
        end
      end
      default: begin
        state_d = INICIAL;
      end
    endcase
  end

  // State and session registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INICIAL;
      sel_q      <= {SEL_W{1'b1}};
      dif_q      <= 1'b0;
      total_q    <= {TOTAL_W{1'b0}};
      partidas_q <= 8'd0;
      sel_inv_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wd_q       <= {WD_W{1'b0}};
      jogar_q    <= {N_GAMES{1'b0}};
      greset_q   <= {N_GAMES{1'b0}};
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dif_q      <= dif_d;
      total_q    <= total_d;
      partidas_q <= partidas_d;
      sel_inv_q  <= sel_inv_d;
      timeout_q  <= timeout_d;
      wd_q       <= wd_d;
      jogar_q    <= jogar_d;
      greset_q   <= greset_d;
    end
  end

  assign game_jogar       = jogar_q;
  assign game_reset       = greset_q | {N_GAMES{reset}};
  assign game_dificuldade = dif_q;
  assign game_botoes      = botoes_s;
  assign minigame_out     = sel_q;
  assign leds_out         = leds_s;
  assign estado_out       = show_s ? estado_mux_s : STATE_W'(state_q);
  assign jogada_out       = jogada_s;
  assign pontuacao_out    = pont_s;
  assign pontuacao_total  = total_q;
  assign partidas         = partidas_q;
  assign sel_invalida     = sel_inv_q;
  assign timeout          = timeout_q;

endmodule

// File: tb/tb_minigame_dispatcher.sv
// Directed bench: instance a uses default parameters, instance b uses TOTAL_W=7 and an 8-cycle watchdog.
module tb_minigame_dispatcher;

  logic        clock;
  logic        reset;
  logic        iniciar;
  logic        abortar;
  logic        dificuldade;
  logic [1:0]  minigame;
  logic [6:0]  botoes;
  logic [2:0]  game_pronto;
  logic [8:0]  game_leds;
  logic [11:0] game_estado;
  logic [20:0] game_jogada;
  logic [20:0] game_pontuacao;

  logic [2:0]  a_jogar, a_greset, b_jogar, b_greset;
  logic        a_dif, b_dif;
  logic [20:0] a_botoes, b_botoes;
  logic [1:0]  a_sel, b_sel;
  logic [2:0]  a_leds, b_leds;
  logic [3:0]  a_estado, b_estado;
  logic [6:0]  a_jogada, b_jogada;
  logic [6:0]  a_pont, b_pont;
  logic [9:0]  a_total;
  logic [6:0]  b_total;
  logic [7:0]  a_partidas, b_partidas;
  logic        a_inv, b_inv, a_to, b_to;

  int n_pass  = 0;
  int n_total = 0;

  minigame_dispatcher #(.TOTAL_W(10), .TIMEOUT_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar), .dificuldade(dificuldade),
    .minigame(minigame), .botoes(botoes), .game_pronto(game_pronto), .game_leds(game_leds),
    .game_estado(game_estado), .game_jogada(game_jogada), .game_pontuacao(game_pontuacao),
    .game_jogar(a_jogar), .game_reset(a_greset), .game_dificuldade(a_dif), .game_botoes(a_botoes),
    .minigame_out(a_sel), .leds_out(a_leds), .estado_out(a_estado), .jogada_out(a_jogada),
    .pontuacao_out(a_pont), .pontuacao_total(a_total), .partidas(a_partidas),
    .sel_invalida(a_inv), .timeout(a_to)
  );

  minigame_dispatcher #(.TOTAL_W(7), .TIMEOUT_CYCLES(8)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar), .dificuldade(dificuldade),
    .minigame(minigame), .botoes(botoes), .game_pronto(game_pronto), .game_leds(game_leds),
    .game_estado(game_estado), .game_jogada(game_jogada), .game_pontuacao(game_pontuacao),
    .game_jogar(b_jogar), .game_reset(b_greset), .game_dificuldade(b_dif), .game_botoes(b_botoes),
    .minigame_out(b_sel), .leds_out(b_leds), .estado_out(b_estado), .jogada_out(b_jogada),
    .pontuacao_out(b_pont), .pontuacao_total(b_total), .partidas(b_partidas),
    .sel_invalida(b_inv), .timeout(b_to)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    reset          = 1'b1;
    iniciar        = 1'b0;
    abortar        = 1'b0;
    dificuldade    = 1'b0;
    minigame       = 2'd0;
    botoes         = 7'h55;
    game_pronto    = 3'b000;
    game_leds      = {3'b100, 3'b010, 3'b001};
    game_estado    = {4'h7, 4'h6, 4'h5};
    game_jogada    = {7'd12, 7'd11, 7'd10};
    game_pontuacao = {7'd100, 7'd30, 7'd20};

    // reset state
    #1;
    chk("rst_game_reset", 32'(a_greset), 32'h7);
    step();
    chk("rst_estado", 32'(a_estado), 32'h0);
    chk("rst_sel", 32'(a_sel), 32'h3);
    chk("rst_total", 32'(a_total), 32'h0);
    chk("rst_partidas", 32'(b_partidas), 32'h0);
    chk("rst_jogar", 32'(a_jogar), 32'h0);
    chk("rst_botoes_idle", 32'(a_botoes), 32'h0);
    reset = 1'b0;
    step();
    chk("rst_game_reset_released", 32'(a_greset), 32'h0);

    // session start on game 1, one-cycle start pulse
    iniciar = 1'b1; minigame = 2'd1; dificuldade = 1'b1;
    step();
    chk("t1_prep", 32'(a_estado), 32'h1);
    iniciar = 1'b0;
    step();
    chk("t1_jogar", 32'(a_jogar), 32'h2);
    chk("t1_sel", 32'(a_sel), 32'h1);
    chk("t1_dif", 32'(a_dif), 32'h1);
    chk("t1_estado_mux", 32'(a_estado), 32'h6);
    chk("t1_leds_mux", 32'(a_leds), 32'h2);
    chk("t1_botoes_route", 32'(a_botoes), 32'h2A80);
    step();
    chk("t1_jogar_once", 32'(a_jogar), 32'h0);
    chk("t1_still_exec", 32'(a_estado), 32'h6);

    // abort and pronto together: abort wins
    abortar = 1'b1; game_pronto = 3'b010;
    step();
    abortar = 1'b0; game_pronto = 3'b000;
    chk("t5_inicial", 32'(a_estado), 32'h0);
    chk("t5_game_reset", 32'(a_greset), 32'h2);
    chk("t5_no_score", 32'(a_total), 32'h0);
    chk("t5_no_partida", 32'(a_partidas), 32'h0);
    step();
    chk("t5_game_reset_pulse", 32'(a_greset), 32'h0);

    // invalid selection held in PREPARACAO, then valid
    iniciar = 1'b1; minigame = 2'd3; dificuldade = 1'b0;
    step();
    iniciar = 1'b0;
    step();
    chk("t2_invalid_flag", 32'(a_inv), 32'h1);
    chk("t2_stay_prep", 32'(a_estado), 32'h1);
    chk("t2_no_jogar", 32'(a_jogar), 32'h0);
    step();
    chk("t2_still_prep", 32'(b_estado), 32'h1);
    minigame = 2'd0;
    step();
    chk("t2_flag_clear", 32'(a_inv), 32'h0);
    chk("t2_jogar0", 32'(a_jogar), 32'h1);
    chk("t2_dif0", 32'(a_dif), 32'h0);
    chk("t2_leds0", 32'(a_leds), 32'h1);

    // pronto from a non-selected game is ignored, then game 0 completes
    game_pronto = 3'b100;
    step();
    chk("t2_foreign_pronto", 32'(a_partidas), 32'h0);
    chk("t2_foreign_exec", 32'(a_botoes), 32'h55);
    game_pronto = 3'b001;
    step();
    game_pronto = 3'b000;
    chk("t3_total_a1", 32'(a_total), 32'd20);
    chk("t3_partidas1", 32'(a_partidas), 32'd1);
    chk("t3_fim_botoes", 32'(a_botoes), 32'h0);
    chk("t3_fim_pont", 32'(a_pont), 32'd20);

    // game 2 completes twice with score 100
    for (int k = 0; k < 2; k++) begin
      iniciar = 1'b1; minigame = 2'd2;
      step();
      iniciar = 1'b0;
      step();
      chk("t3_jogar2", 32'(a_jogar), 32'h4);
      game_pronto = 3'b100;
      step();
      game_pronto = 3'b000;
    end
    chk("t3_total_a", 32'(a_total), 32'd220);
    chk("t3_total_b_sat", 32'(b_total), 32'd127);
    chk("t3_partidas3", 32'(a_partidas), 32'd3);
    chk("t3_pont_mux", 32'(b_pont), 32'd100);
    chk("t3_jogada_mux", 32'(b_jogada), 32'd12);

    // watchdog: b ends 8 cycles after entry, a has no watchdog
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    for (int k = 0; k < 7; k++) step();
    chk("t4_b_before_to", 32'(b_botoes), 32'h154000);
    chk("t4_b_to_low", 32'(b_to), 32'h0);
    step();
    chk("t4_b_timeout", 32'(b_to), 32'h1);
    chk("t4_b_fim", 32'(b_botoes), 32'h0);
    chk("t4_b_total", 32'(b_total), 32'd127);
    chk("t4_b_partidas", 32'(b_partidas), 32'd3);
    chk("t4_a_exec", 32'(a_botoes), 32'h154000);
    chk("t4_a_no_to", 32'(a_to), 32'h0);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk("t4_b_to_clear", 32'(b_to), 32'h0);
    chk("t4_b_prep", 32'(b_estado), 32'h1);
    chk("t4_a_ignores_iniciar", 32'(a_estado), 32'h7);

    // reset in the middle of EXECUCAO
    reset = 1'b1;
    #1;
    chk("t6_game_reset_all", 32'(a_greset), 32'h7);
    step();
    reset = 1'b0;
    chk("t6_estado", 32'(a_estado), 32'h0);
    chk("t6_sel", 32'(a_sel), 32'h3);
    chk("t6_total", 32'(a_total), 32'h0);
    chk("t6_partidas", 32'(a_partidas), 32'h0);
    chk("t6_b_total", 32'(b_total), 32'h0);
    chk("t6_flags", 32'({a_inv, a_to, a_dif}), 32'h0);
    chk("t6_botoes", 32'(a_botoes), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
